// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver
// Multiplexed 4-digit seven-segment scanner with per-slot dead time,
// frame-latched segment/brightness shadows and 16-step PWM digit dimming.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] seg_word,
  input  logic [3:0]  brightness,
  input  logic        enable,
  output logic [7:0]  seg_n,
  output logic [3:0]  dig_n,
  output logic        frame_tick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam logic [19:0] C_BLANK_LAST = 20'(BLANK_TICKS - 1);
  localparam logic [19:0] C_SLOT_LAST  = 20'(DIGIT_TICKS - 1);

  logic [1:0]  state_q, state_d;
  logic [19:0] t_q, t_d;
  logic [1:0]  digit_q, digit_d;
  logic [3:0]  p_q, p_d;
  logic [31:0] shadow_seg_q, shadow_seg_d;
  logic [3:0]  shadow_br_q, shadow_br_d;
  logic [7:0]  seg_n_q, seg_n_d;
  logic [3:0]  dig_n_q, dig_n_d;
  logic        frame_tick_q, frame_tick_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      digit_q      <= '0;
      p_q          <= '0;
      shadow_seg_q <= 32'hFFFF_FFFF;
      shadow_br_q  <= 4'hF;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      digit_q      <= digit_d;
      p_q          <= p_d;
      shadow_seg_q <= shadow_seg_d;
      shadow_br_q  <= shadow_br_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    digit_d      = digit_q;
    p_d          = p_q;
    frame_tick_d = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      t_d     = '0;
      digit_d = '0;
      p_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_BLANK;
          t_d          = '0;
          digit_d      = '0;
          frame_tick_d = 1'b1;
        end
        S_BLANK: begin
          t_d = t_q + 20'd1;
          if (t_q == C_BLANK_LAST) begin
            state_d = S_DRIVE;
            p_d     = '0;
          end
        end
        S_DRIVE: begin
          p_d = p_q + 4'd1;
          if (t_q == C_SLOT_LAST) begin
            t_d          = '0;
            state_d      = S_BLANK;
            digit_d      = digit_q + 2'd1;
            frame_tick_d = (digit_q == 2'd3);
          end else begin
            t_d = t_q + 20'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          t_d     = '0;
          digit_d = '0;
          p_d     = '0;
        end
      endcase
    end
  end

  // Outputs are derived from next-state values so the registered output lines
  // up with the registered state in the same cycle.
  always_comb begin
    shadow_seg_d = frame_tick_d ? seg_word   : shadow_seg_q;
    shadow_br_d  = frame_tick_d ? brightness : shadow_br_q;
    seg_n_d      = 8'hFF;
    dig_n_d      = 4'hF;
    if (state_d == S_DRIVE) begin
      seg_n_d = shadow_seg_d[{digit_d, 3'b000} +: 8];
      if (p_d <= shadow_br_d) begin
        dig_n_d = ~(4'b0001 << digit_d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n_q      <= 8'hFF;
      dig_n_q      <= 4'hF;
      frame_tick_q <= 1'b0;
    end else begin
      seg_n_q      <= seg_n_d;
      dig_n_q      <= dig_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dig_n      = dig_n_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: two instances (20- and 36-tick
// slots) compared against a frame-position reference model.
`default_nettype none

module tb_seg7_scan_driver;

  localparam int BT = 4;

  logic        clk, reset_n, enable;
  logic [31:0] seg_word;
  logic [3:0]  brightness;
  logic [7:0]  seg20, seg36;
  logic [3:0]  dig20, dig36;
  logic        ft20, ft36;

  int errors = 0;
  int checks = 0;

  seg7_scan_driver #(.DIGIT_TICKS(20), .BLANK_TICKS(BT)) dut20 (
    .clk(clk), .reset_n(reset_n), .seg_word(seg_word), .brightness(brightness),
    .enable(enable), .seg_n(seg20), .dig_n(dig20), .frame_tick(ft20));

  seg7_scan_driver #(.DIGIT_TICKS(36), .BLANK_TICKS(BT)) dut36 (
    .clk(clk), .reset_n(reset_n), .seg_word(seg_word), .brightness(brightness),
    .enable(enable), .seg_n(seg36), .dig_n(dig36), .frame_tick(ft36));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position k within the current frame plus frame-latched inputs.
  logic        m_run;
  int          m_k20, m_k36;
  logic [31:0] m_sw20, m_sw36;
  logic [3:0]  m_br20, m_br36;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 1'b0; m_k20 = 0; m_k36 = 0;
      m_sw20 = 32'hFFFF_FFFF; m_sw36 = 32'hFFFF_FFFF;
      m_br20 = 4'hF; m_br36 = 4'hF;
    end else if (!enable) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_k20 = 0; m_k36 = 0;
      m_sw20 = seg_word; m_sw36 = seg_word;
      m_br20 = brightness; m_br36 = brightness;
    end else begin
      m_k20 = (m_k20 + 1) % 80;
      m_k36 = (m_k36 + 1) % 144;
      if (m_k20 == 0) begin m_sw20 = seg_word; m_br20 = brightness; end
      if (m_k36 == 0) begin m_sw36 = seg_word; m_br36 = brightness; end
    end
  end

  // Expected {frame_tick, seg_n, dig_n} for frame position k.
  function automatic logic [12:0] exp_out(input logic run, input int k, input int dt,
                                          input logic [31:0] sw, input logic [3:0] br);
    int slot, pos, p;
    logic [7:0] s;
    logic [3:0] dg;
    if (!run) return {1'b0, 8'hFF, 4'hF};
    slot = k / dt;
    pos  = k % dt;
    if (pos < BT) return {(k == 0), 8'hFF, 4'hF};
    s  = 8'(sw >> (8 * slot));
    p  = (pos - BT) % 16;
    dg = (p <= int'(br)) ? 4'(~(4'b0001 << slot)) : 4'hF;
    return {1'b0, s, dg};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1;
    seg_word = 32'hC8F9C092; brightness = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ft20, seg20, dig20} !== {1'b0, 8'hFF, 4'hF}) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got tick=%b seg=%h dig=%h want 0/FF/F", i, ft20, seg20, dig20);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ft20, seg20, dig20} !== {1'b1, 8'hFF, 4'hF}) begin
      errors++;
      $display("FAIL reset_resume: got tick=%b seg=%h dig=%h want 1/FF/F", ft20, seg20, dig20);
    end
    repeat (6) @(negedge clk);
    checks++;
    if ({seg20, dig20} !== {8'h92, 4'hE}) begin
      errors++;
      $display("FAIL reset_predrive: got seg=%h dig=%h want 92/E", seg20, dig20);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ft20, seg20, dig20} !== {1'b0, 8'hFF, 4'hF}) begin
      errors++;
      $display("FAIL reset_async: got tick=%b seg=%h dig=%h want 0/FF/F", ft20, seg20, dig20);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_scan_order();
    int ticks;
    logic [12:0] e, c;
    do_reset();
    seg_word = 32'hC8F9C092; brightness = 4'hF; enable = 1'b1;
    ticks = 0;
    for (int off = 0; off < 160; off++) begin
      @(negedge clk);
      ticks += int'(ft20);
      e = exp_out(m_run, m_k20, 20, m_sw20, m_br20);
      checks++;
      if ({ft20, seg20, dig20} !== e) begin
        errors++;
        $display("FAIL scan_model off%0d: got %h want %h", off, {ft20, seg20, dig20}, e);
      end
      c = 13'h1FFF;
      case (off % 80)
        0:      c = {1'b1, 8'hFF, 4'hF};
        3, 20:  c = {1'b0, 8'hFF, 4'hF};
        4, 19:  c = {1'b0, 8'h92, 4'hE};
        24:     c = {1'b0, 8'hC0, 4'hD};
        44:     c = {1'b0, 8'hF9, 4'hB};
        64, 79: c = {1'b0, 8'hC8, 4'h7};
        default: c = 13'h1FFF;
      endcase
      if (c != 13'h1FFF) begin
        checks++;
        if ({ft20, seg20, dig20} !== c) begin
          errors++;
          $display("FAIL scan_spot off%0d: got %h want %h", off, {ft20, seg20, dig20}, c);
        end
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL scan_ticks: got %0d want 2", ticks);
    end
  endtask

  task automatic test_tear_free();
    logic [12:0] e;
    do_reset();
    seg_word = 32'hC8F9C092; brightness = 4'hF; enable = 1'b1;
    @(negedge clk);
    repeat (25) @(negedge clk);
    seg_word = 32'h0000_0000;
    for (int off = 26; off < 80; off++) begin
      @(negedge clk);
      e = exp_out(m_run, m_k20, 20, m_sw20, m_br20);
      checks++;
      if (seg20 === 8'h00 || {ft20, seg20, dig20} !== e) begin
        errors++;
        $display("FAIL tear_old off%0d: got %h want %h", off, {ft20, seg20, dig20}, e);
      end
    end
    @(negedge clk);
    checks++;
    if (ft20 !== 1'b1) begin
      errors++;
      $display("FAIL tear_tick: got %b want 1", ft20);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({seg20, dig20} !== {8'h00, 4'hE}) begin
      errors++;
      $display("FAIL tear_new: got seg=%h dig=%h want 00/E", seg20, dig20);
    end
  endtask

  task automatic test_pwm();
    int lows;
    do_reset();
    seg_word = $urandom; brightness = 4'd0; enable = 1'b1;
    @(negedge clk);
    lows = 0;
    for (int off = 0; off < 36; off++) begin
      if (dig36 == 4'hE) lows++;
      @(negedge clk);
    end
    checks++;
    if (lows != 2) begin
      errors++;
      $display("FAIL pwm_b0: got %0d low cycles want 2", lows);
    end
    brightness = 4'd7;
    lows = 0;
    for (int off = 36; off < 72; off++) begin
      if (dig36 == 4'hD) lows++;
      @(negedge clk);
    end
    checks++;
    if (lows != 2) begin
      errors++;
      $display("FAIL pwm_latched: got %0d low cycles want 2", lows);
    end
    repeat (144 - 72) @(negedge clk);
    lows = 0;
    for (int off = 144; off < 180; off++) begin
      if (dig36 == 4'hE) lows++;
      @(negedge clk);
    end
    checks++;
    if (lows != 16) begin
      errors++;
      $display("FAIL pwm_b7: got %0d low cycles want 16", lows);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    seg_word = 32'hC8F9C092; brightness = 4'hF; enable = 1'b1;
    @(negedge clk);
    repeat (46) @(negedge clk);
    checks++;
    if ({seg20, dig20} !== {8'hF9, 4'hB}) begin
      errors++;
      $display("FAIL drop_pre: got seg=%h dig=%h want F9/B", seg20, dig20);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({ft20, seg20, dig20} !== {1'b0, 8'hFF, 4'hF}) begin
      errors++;
      $display("FAIL drop_off: got %h want 0FF F", {ft20, seg20, dig20});
    end
    repeat (9) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({ft20, seg20, dig20} !== {1'b1, 8'hFF, 4'hF}) begin
      errors++;
      $display("FAIL drop_restart: got %h want 1/FF/F", {ft20, seg20, dig20});
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ft20, seg20, dig20} !== {1'b0, 8'hFF, 4'hF}) begin
        errors++;
        $display("FAIL drop_blank%0d: got %h want 0/FF/F", i, {ft20, seg20, dig20});
      end
    end
    @(negedge clk);
    checks++;
    if ({seg20, dig20} !== {8'h92, 4'hE}) begin
      errors++;
      $display("FAIL drop_digit0: got seg=%h dig=%h want 92/E", seg20, dig20);
    end
  endtask

  task automatic test_random();
    logic [12:0] e20, e36;
    logic prev20, prev36;
    do_reset();
    seg_word = $urandom; brightness = 4'($urandom); enable = 1'b1;
    prev20 = 1'b0; prev36 = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      e20 = exp_out(m_run, m_k20, 20, m_sw20, m_br20);
      e36 = exp_out(m_run, m_k36, 36, m_sw36, m_br36);
      checks++;
      if ({ft20, seg20, dig20} !== e20) begin
        errors++;
        $display("FAIL rand20 cyc%0d: got %h want %h", cyc, {ft20, seg20, dig20}, e20);
      end
      checks++;
      if ({ft36, seg36, dig36} !== e36) begin
        errors++;
        $display("FAIL rand36 cyc%0d: got %h want %h", cyc, {ft36, seg36, dig36}, e36);
      end
      checks++;
      if (!(dig20 inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}) ||
          !(dig36 inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
        errors++;
        $display("FAIL rand_onehot cyc%0d: got dig20=%h dig36=%h want one-low or F", cyc, dig20, dig36);
      end
      checks++;
      if ((prev20 && ft20) || (prev36 && ft36)) begin
        errors++;
        $display("FAIL rand_tick_pair cyc%0d: got back-to-back frame_tick want isolated", cyc);
      end
      prev20 = ft20; prev36 = ft36;
      if ($urandom_range(7) == 0)   seg_word   = $urandom;
      if ($urandom_range(15) == 0)  brightness = 4'($urandom);
      if ($urandom_range(299) == 0) enable     = ~enable;
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; seg_word = '0; brightness = '0;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_pwm();
    test_enable_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
